neuron_input_loader: RTL and testbench

Upstream feeder for the combinational neuron stage. It collects one DW-bit input word per cycle over a valid/ready stream and assembles the N_IN-word input vector. It also holds the N_IN+1 constant words (N_IN weights plus bias), which are written through a config port. It presents a stable vector/constant set to the neuron with a valid/ready handoff, so the neuron output can be sampled by the consumer.

---
 rtl/neuron_input_loader.sv | 118 +++++++++++
 tb/tb_neuron_input_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_input_loader.sv
// neuron_input_loader: assembles an N_IN-word input vector from a stream and holds neuron constants for handoff.
// Optional frame counter enabled by NEURON_LOADER_FRAMECNT_EN; otherwise frame_cnt reads zero.
module neuron_input_loader #(
    parameter int N_IN = 32,
    parameter int DW   = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DW-1:0]               in_data,
    input  logic                        in_last,
    input  logic                        cfg_we,
    output logic                        cfg_ready,
    input  logic [$clog2(N_IN+1)-1:0]   cfg_addr,
    input  logic [DW-1:0]               cfg_data,
    output logic [N_IN*DW-1:0]          vec_out,
    output logic [(N_IN+1)*DW-1:0]      const_out,
    output logic                        vec_valid,
    input  logic                        vec_ready,
    output logic                        err_short,
    output logic                        err_long,
    input  logic                        err_clr,
    output logic [15:0]                 frame_cnt
);
    localparam int AW = $clog2(N_IN+1);
    localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {FILL, DROP, HOLD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            err_short_q, err_short_d, err_long_q, err_long_d;
    logic [DW-1:0]   vec_q   [N_IN];
    logic [DW-1:0]   const_q [N_IN+1];
    logic            accept, handoff, last_slot;

    assign accept    = in_valid && in_ready;
    assign handoff   = (state_q == HOLD) && vec_ready;
    assign last_slot = idx_q == IW'(N_IN-1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_short_d = err_short_q && !err_clr;
        err_long_d  = err_long_q && !err_clr;
        case (state_q)
            FILL: if (accept) begin
                idx_d = idx_q + IW'(1);
                if (in_last) begin
                    state_d     = HOLD;
                    err_short_d = err_short_d || !last_slot;
                end else if (last_slot) begin
                    state_d    = DROP;
                    err_long_d = 1'b1;
                end
            end
            DROP: state_d = (accept && in_last) ? HOLD : DROP;
            default: if (vec_ready) begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = state_q != HOLD;
        cfg_ready = state_q != HOLD;
        vec_valid = state_q == HOLD;
        vec_out   = '0;
        const_out = '0;
        for (int i = 0; i < N_IN; i++) vec_out[i*DW +: DW] = vec_q[i];
        for (int j = 0; j <= N_IN; j++) const_out[j*DW +: DW] = const_q[j];
    end

    assign err_short = err_short_q;
    assign err_long  = err_long_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) vec_q[i] <= '0;
            for (int j = 0; j <= N_IN; j++) const_q[j] <= '0;
        end else begin
            if (handoff) begin
                for (int i = 0; i < N_IN; i++) vec_q[i] <= '0;
            end else if (state_q == FILL && accept) begin
                vec_q[idx_q] <= in_data;
            end
            // out-of-range constant addresses are silently dropped
            if (cfg_we && cfg_ready && cfg_addr <= AW'(N_IN)) const_q[cfg_addr] <= cfg_data;
        end
    end

`ifdef NEURON_LOADER_FRAMECNT_EN
    logic [15:0] frame_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_q <= '0;
        else if (handoff) frame_q <= frame_q + 16'd1;
    end
    assign frame_cnt = frame_q;
`else
    assign frame_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_neuron_input_loader.sv
// tb_neuron_input_loader: directed, table-driven and random checks of neuron_input_loader against a frame-level model.
module tb_neuron_input_loader;
    localparam int N  = 32;
    localparam int DW = 32;
    localparam int AW = $clog2(N+1);

    logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, cfg_we = 0, vec_ready = 0, err_clr = 0;
    logic [DW-1:0] in_data = 0, cfg_data = 0;
    logic [AW-1:0] cfg_addr = 0;
    logic in_ready, cfg_ready, vec_valid, err_short, err_long;
    logic [N*DW-1:0] vec_out;
    logic [(N+1)*DW-1:0] const_out;
    logic [15:0] frame_cnt;

    neuron_input_loader #(.N_IN(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .vec_out(vec_out), .const_out(const_out), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .err_short(err_short), .err_long(err_long), .err_clr(err_clr),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // frame-level reference: words seen in the current frame, whether it is being held
    logic [DW-1:0] m_vec [N];
    logic [DW-1:0] m_const [N+1];
    int m_cnt, m_frames;
    bit m_hold, m_es, m_el;

    typedef struct {
        logic v; logic [31:0] d; logic l; logic vr; logic clr;
        logic e_rdy; logic e_vv; logic e_es; logic e_el;
    } row_t;
    row_t tbl [7];

    task automatic mreset();
        foreach (m_vec[i]) m_vec[i] = '0;
        foreach (m_const[j]) m_const[j] = '0;
        m_cnt = 0; m_frames = 0; m_hold = 0; m_es = 0; m_el = 0;
    endtask

    task automatic model_step();
        if (err_clr) begin m_es = 0; m_el = 0; end
        if (cfg_we && !m_hold && int'(cfg_addr) <= N) m_const[cfg_addr] = cfg_data;
        if (m_hold) begin
            if (vec_ready) begin
                m_hold = 0; m_cnt = 0; m_frames = (m_frames + 1) % 65536;
                foreach (m_vec[i]) m_vec[i] = '0;
            end
        end else if (in_valid) begin
            if (m_cnt < N) m_vec[m_cnt] = in_data;
            m_cnt++;
            if (in_last) begin
                m_hold = 1;
                if (m_cnt < N) m_es = 1;
            end else if (m_cnt == N) m_el = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int bad;
        logic [15:0] efc;
`ifdef NEURON_LOADER_FRAMECNT_EN
        efc = 16'(m_frames);
`else
        efc = 16'h0000;
`endif
        chk("in_ready", 32'(in_ready), 32'(!m_hold));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_hold));
        chk("vec_valid", 32'(vec_valid), 32'(m_hold));
        chk("err_short", 32'(err_short), 32'(m_es));
        chk("err_long", 32'(err_long), 32'(m_el));
        chk("frame_cnt", 32'(frame_cnt), 32'(efc));
        bad = -1;
        for (int i = N-1; i >= 0; i--) if (vec_out[i*DW +: DW] !== m_vec[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL vec_word[%0d]: got %h expected %h at %0t", bad, vec_out[bad*DW +: DW], m_vec[bad], $time);
        end
        bad = -1;
        for (int j = N; j >= 0; j--) if (const_out[j*DW +: DW] !== m_const[j]) bad = j;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL const_word[%0d]: got %h expected %h at %0t", bad, const_out[bad*DW +: DW], m_const[bad], $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic we,
                         input logic [AW-1:0] a, input logic [31:0] cd, input logic vr, input logic clr);
        in_valid = v; in_data = d; in_last = l; cfg_we = we;
        cfg_addr = a; cfg_data = cd; vec_ready = vr; err_clr = clr;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] w;
        tbl[0] = '{1, 32'd1, 0, 0, 0, 1, 0, 0, 0};
        tbl[1] = '{1, 32'd2, 0, 0, 0, 1, 0, 0, 0};
        tbl[2] = '{1, 32'd3, 0, 0, 0, 1, 0, 0, 0};
        tbl[3] = '{1, 32'd4, 0, 0, 0, 1, 0, 0, 0};
        tbl[4] = '{1, 32'd5, 1, 0, 0, 0, 1, 1, 0};
        tbl[5] = '{0, 32'd0, 0, 1, 0, 1, 0, 1, 0};
        tbl[6] = '{0, 32'd0, 0, 0, 1, 1, 0, 0, 0};

        mreset();
        #12;
        check_all();
        @(negedge clk) rst_n = 1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        for (int a = 0; a <= N; a++) begin
            drive(0, 0, 0, 1, AW'(a), 32'd8, 0, 0);
            tick();
        end
        for (int i = 0; i < N; i++) begin
            w = i * 32'h3fffffff;
            drive(1, w, i == N-1, 0, 0, 0, 0, 0);
            tick();
            if (i == N-2) chk("t1_vv_early", 32'(vec_valid), 32'd0);
        end
        w = 31 * 32'h3fffffff;
        chk("t1_vv", 32'(vec_valid), 32'd1);
        chk("t1_rdy", 32'(in_ready), 32'd0);
        chk("t1_w31", vec_out[31*DW +: DW], w);
        chk("t1_c32", const_out[32*DW +: DW], 32'd8);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("t2_vv", 32'(vec_valid), 32'd0);
        chk("t2_rdy", 32'(in_ready), 32'd1);
        chk("t2_w31", vec_out[31*DW +: DW], 32'd0);
`ifdef NEURON_LOADER_FRAMECNT_EN
        chk("t2_fc", 32'(frame_cnt), 32'd1);
`else
        chk("t2_fc", 32'(frame_cnt), 32'd0);
`endif

        for (int r = 0; r < 7; r++) begin
            drive(tbl[r].v, tbl[r].d, tbl[r].l, 0, 0, 0, tbl[r].vr, tbl[r].clr);
            tick();
            chk($sformatf("t3_rdy[%0d]", r), 32'(in_ready), 32'(tbl[r].e_rdy));
            chk($sformatf("t3_vv[%0d]", r), 32'(vec_valid), 32'(tbl[r].e_vv));
            chk($sformatf("t3_es[%0d]", r), 32'(err_short), 32'(tbl[r].e_es));
            chk($sformatf("t3_el[%0d]", r), 32'(err_long), 32'(tbl[r].e_el));
            if (r == 4) chk("t3_w4", vec_out[4*DW +: DW], 32'd5);
        end

        for (int i = 0; i < 35; i++) begin
            drive(1, 32'hA0 + i, i == 34, 0, 0, 0, 0, 0);
            tick();
            if (i == 33) chk("t4_vv_early", 32'(vec_valid), 32'd0);
        end
        chk("t4_vv", 32'(vec_valid), 32'd1);
        chk("t4_el", 32'(err_long), 32'd1);
        chk("t4_w31", vec_out[31*DW +: DW], 32'hBF);

        drive(0, 0, 0, 1, AW'(3), 32'h55, 0, 1);
        tick();
        chk("t5_cfg_rdy", 32'(cfg_ready), 32'd0);
        chk("t5_c3", const_out[3*DW +: DW], 32'd8);
        chk("t5_el_clr", 32'(err_long), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, AW'(40), 32'h99, 0, 0);
        tick();
        drive(1, 32'h1234, 0, 1, AW'(32), 32'h77, 0, 0);
        tick();
        chk("t5_c32", const_out[32*DW +: DW], 32'h77);
        chk("t5_w0", vec_out[0 +: DW], 32'h1234);

        for (int i = 1; i < 10; i++) begin
            drive(1, 32'(i), 0, 0, 0, 0, 0, 0);
            tick();
        end
        #2 rst_n = 0;
        #1;
        mreset();
        check_all();
        chk("t6_w9", vec_out[9*DW +: DW], 32'd0);
        chk("t6_c32", const_out[32*DW +: DW], 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1;
        #1;
        chk("t6_rdy", 32'(in_ready), 32'd1);
        chk("t6_vv", 32'(vec_valid), 32'd0);
        chk("t6_fc", 32'(frame_cnt), 32'd0);
        drive(1, 32'hCAFE, 1, 0, 0, 0, 0, 0);
        tick();
        chk("t6_w0", vec_out[0 +: DW], 32'hCAFE);
        chk("t6_es", 32'(err_short), 32'd1);

        repeat (3000) begin
            drive($urandom_range(1), $urandom, $urandom_range(19) == 0, $urandom_range(3) == 0,
                  AW'($urandom_range(40)), $urandom, $urandom_range(9) < 3, $urandom_range(19) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
